decode_queue_ctrl: RTL and testbench

DECODE_QUEUE_CTRL -- requirements
Module: decode_queue_ctrl

---
 rtl/decode_queue_ctrl.sv | 96 +++++++++
 tb/tb_decode_queue_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue_ctrl.sv
// Fetch-to-decode instruction queue: circular FIFO with a two-state controller that
// stops accepting entries after one carrying a fetch exception, until a flush.
module decode_queue_ctrl #(
  parameter int VADDR_WIDTH      = 32,
  parameter int MAX_ILEN         = 32,
  parameter int XCPT_CAUSE_WIDTH = 32,
  parameter int DEPTH            = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          instr_valid_i,
  output logic                          instr_ready_o,
  input  logic [VADDR_WIDTH-1:0]        instr_pc_i,
  input  logic [MAX_ILEN-1:0]           instr_content_i,
  input  logic                          xcpt_valid_i,
  input  logic [XCPT_CAUSE_WIDTH-1:0]   xcpt_cause_i,
  input  logic                          flush_i,
  output logic                          deco_valid_o,
  input  logic                          deco_ready_i,
  output logic [VADDR_WIDTH-1:0]        deco_pc_o,
  output logic [MAX_ILEN-1:0]           deco_instr_o,
  output logic                          deco_xcpt_valid_o,
  output logic [XCPT_CAUSE_WIDTH-1:0]   deco_xcpt_cause_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = VADDR_WIDTH + MAX_ILEN + 1 + XCPT_CAUSE_WIDTH;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic {
    RUN   = 1'b0,
    XHOLD = 1'b1
  } state_t;

  state_t          state_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic [EW-1:0]   mem [DEPTH];

  logic            push;
  logic            pop;
  logic [EW-1:0]   wr_entry;
  logic [EW-1:0]   head_entry;

  // Flush blocks both handshakes so nothing moves in the cycle being discarded.
  assign instr_ready_o = (count_reg < FULL_COUNT) && (state_reg == RUN) && !flush_i;
  assign deco_valid_o  = (count_reg != '0) && !flush_i;

  assign push = instr_valid_i && instr_ready_o;
  assign pop  = deco_valid_o && deco_ready_i;

  assign wr_entry   = {instr_pc_i, instr_content_i, xcpt_valid_i, xcpt_cause_i};
  assign head_entry = mem[rd_ptr_reg];

  assign {deco_pc_o, deco_instr_o, deco_xcpt_valid_o, deco_xcpt_cause_o} = head_entry;
  assign count_o = count_reg;
  assign state_o = state_reg;

  // Entry storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_entry;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      state_reg  <= RUN;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
      // Once a faulting entry is queued, younger fetches are wrong-path until flushed.
      case (state_reg)
        RUN:     if (push && xcpt_valid_i) state_reg <= XHOLD;
        XHOLD:   state_reg <= XHOLD;
        default: state_reg <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_queue_ctrl.sv
// Self-checking bench for decode_queue_ctrl: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_decode_queue_ctrl;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        xv;
    logic [31:0] xc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        xv;
  logic [31:0] xc;
  logic        flush;
  logic        deco_valid;
  logic        deco_ready;
  logic [31:0] deco_pc;
  logic [31:0] deco_instr;
  logic        deco_xv;
  logic [31:0] deco_xc;
  logic [2:0]  count;
  logic        state;

  int checks = 0;
  int errors = 0;

  ent_t q[$];
  bit   hold = 0;

  always #5 clk = ~clk;

  decode_queue_ctrl #(
    .VADDR_WIDTH(32), .MAX_ILEN(32), .XCPT_CAUSE_WIDTH(32), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_valid_i(in_valid), .instr_ready_o(in_ready),
    .instr_pc_i(pc), .instr_content_i(instr),
    .xcpt_valid_i(xv), .xcpt_cause_i(xc),
    .flush_i(flush),
    .deco_valid_o(deco_valid), .deco_ready_i(deco_ready),
    .deco_pc_o(deco_pc), .deco_instr_o(deco_instr),
    .deco_xcpt_valid_o(deco_xv), .deco_xcpt_cause_o(deco_xc),
    .count_o(count), .state_o(state)
  );

  // Advance one clock and apply the handshake rules to the reference model.
  task automatic cycle();
    bit   do_push;
    bit   do_pop;
    ent_t e;
    do_push = in_valid && (q.size() < DEPTH) && !hold && !flush;
    do_pop  = (q.size() != 0) && !flush && deco_ready;
    e.pc = pc; e.instr = instr; e.xv = xv; e.xc = xc;
    @(posedge clk);
    #1;
    if (rst || flush) begin
      q.delete();
      hold = 0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(e);
        if (e.xv) hold = 1;
      end
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] p, input bit x,
                       input logic [31:0] c, input bit f, input bit r);
    in_valid = v; pc = p; instr = ~p; xv = x; xc = c; flush = f; deco_ready = r;
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    drive(1, 32'h44, 0, 0, 1, 1);
    cycle();
    cycle();
    checks++;
    if (deco_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid_during got %0h exp 0", deco_valid);
    end
    rst = 0;
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h exp 1", in_ready); end
    checks++;
    if (deco_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", deco_valid); end
    checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++;
    if (state !== 1'b0) begin errors++; $display("FAIL reset_state got %0h exp 0", state); end
  endtask

  task automatic test_basic_push();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h100 + 32'(4 * i), 0, 0, 0, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (count !== 3'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", count); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (deco_pc !== 32'h100) begin
        errors++; $display("FAIL basic_head_stable got %0h exp 100", deco_pc);
      end
      cycle();
      drive(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_drain();
    logic [31:0] exp_pc;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      exp_pc = 32'h100 + 32'(4 * i);
      checks++;
      if (deco_valid !== 1'b1 || deco_pc !== exp_pc) begin
        errors++; $display("FAIL drain_order got v=%0h pc=%0h exp v=1 pc=%0h", deco_valid, deco_pc, exp_pc);
      end
      $display("drain pop pc=%0h", deco_pc);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 1);
    checks++;
    if (count !== 3'd0 || deco_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty got count=%0d v=%0h exp 0 0", count, deco_valid);
    end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'h300 + 32'(4 * i), 0, 0, 0, 0);
      cycle();
    end
    drive(1, 32'h310, 0, 0, 0, 1);
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0 || deco_valid !== 1'b1) begin
      errors++; $display("FAIL full_cycle got count=%0d rdy=%0h v=%0h exp 4 0 1", count, in_ready, deco_valid);
    end
    cycle();
    drive(1, 32'h314, 0, 0, 0, 1);
    checks++;
    if (count !== 3'd3 || in_ready !== 1'b1) begin
      errors++; $display("FAIL full_after_pop got count=%0d rdy=%0h exp 3 1", count, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h318 + 32'(4 * i), 0, 0, 0, (i % 2) == 0);
      checks++;
      if (count !== 3'(q.size()) || in_ready !== (q.size() < DEPTH) || deco_pc !== q[0].pc) begin
        errors++; $display("FAIL full_steady got count=%0d rdy=%0h pc=%0h exp %0d %0h %0h",
                           count, in_ready, deco_pc, q.size(), q.size() < DEPTH, q[0].pc);
      end
      cycle();
    end
    drive(0, 0, 0, 0, 1, 0);
    cycle();
  endtask

  task automatic test_xcpt_hold();
    drive(1, 32'h200, 1, 32'h2, 0, 0);
    cycle();
    drive(1, 32'h204, 0, 0, 0, 0);
    checks++;
    if (state !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL xcpt_hold got state=%0h rdy=%0h exp 1 0", state, in_ready);
    end
    checks++;
    if (deco_pc !== 32'h200 || deco_xv !== 1'b1 || deco_xc !== 32'h2) begin
      errors++; $display("FAIL xcpt_head got pc=%0h xv=%0h xc=%0h exp 200 1 2", deco_pc, deco_xv, deco_xc);
    end
    cycle();
    drive(1, 32'h208, 0, 0, 0, 1);
    checks++;
    if (count !== 3'd1) begin errors++; $display("FAIL xcpt_no_push got %0d exp 1", count); end
    cycle();
    drive(1, 32'h20c, 0, 0, 0, 1);
    checks++;
    if (count !== 3'd0 || in_ready !== 1'b0 || state !== 1'b1) begin
      errors++; $display("FAIL xcpt_after_drain got count=%0d rdy=%0h state=%0h exp 0 0 1", count, in_ready, state);
    end
    drive(0, 0, 0, 0, 1, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (state !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL xcpt_release got state=%0h rdy=%0h exp 0 1", state, in_ready);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h400 + 32'(4 * i), 0, 0, 0, 0);
      cycle();
    end
    drive(1, 32'h40c, 0, 0, 1, 1);
    checks++;
    if (count !== 3'd3 || deco_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_cycle got count=%0d v=%0h rdy=%0h exp 3 0 0", count, deco_valid, in_ready);
    end
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (count !== 3'd0 || state !== 1'b0 || in_ready !== 1'b1 || deco_valid !== 1'b0) begin
      errors++; $display("FAIL flush_after got count=%0d state=%0h rdy=%0h v=%0h exp 0 0 1 0",
                         count, state, in_ready, deco_valid);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    for (int i = 0; i <= 10; i++) begin
      drive(i < 10, 32'(4 * i), 0, 0, 0, 1);
      if (i > 0) begin
        exp_pc = 32'(4 * (i - 1));
        checks++;
        if (deco_valid !== 1'b1 || deco_pc !== exp_pc) begin
          errors++; $display("FAIL wrap_order got v=%0h pc=%0h exp 1 %0h", deco_valid, deco_pc, exp_pc);
        end
        $display("wrap pop pc=%0h", deco_pc);
      end
      checks++;
      if (count > 3'd1) begin errors++; $display("FAIL wrap_count got %0d exp <=1", count); end
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL wrap_end got %0d exp 0", count); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 15) == 0,
            32'($urandom_range(0, 15)), $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
      checks++;
      if (in_ready !== ((q.size() < DEPTH) && !hold && !flush) ||
          deco_valid !== ((q.size() != 0) && !flush) ||
          count !== 3'(q.size()) || state !== hold) begin
        errors++; $display("FAIL rand_ctrl n=%0d got rdy=%0h v=%0h count=%0d state=%0h exp count=%0d hold=%0h",
                           n, in_ready, deco_valid, count, state, q.size(), hold);
      end
      if (q.size() != 0) begin
        checks++;
        if (deco_pc !== q[0].pc || deco_instr !== q[0].instr ||
            deco_xv !== q[0].xv || deco_xc !== q[0].xc) begin
          errors++; $display("FAIL rand_head n=%0d got pc=%0h xv=%0h exp pc=%0h xv=%0h",
                             n, deco_pc, deco_xv, q[0].pc, q[0].xv);
        end
      end
      cycle();
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_basic_push();
    test_drain();
    test_full_pop();
    test_xcpt_hold();
    test_flush();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
